// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor slice.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_W = 16;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result valid/ready channels of the serial subtractor.
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int W = DEFAULT_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  modport master (
    output in_valid, in1, in2, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit subtractor cell: d = a - b - br_in, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~a & br_in) | (b & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: diff = in1 - in2 - bin, LSB first, one bit per clock,
// with a held result on a valid/ready output channel.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int                CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(W - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             br_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [W-1:0]     diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             d_s;
  logic             br_out_s;

  full_subtractor u_cell (
    .a      (a_r[0]),
    .b      (b_r[0]),
    .br_in  (br_r),
    .d      (d_s),
    .br_out (br_out_s)
  );

  // Control FSM, shift datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      br_r        <= 1'b0;
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.in1;
            b_r        <= bus.in2;
            br_r       <= bus.bin;
            a_msb_r    <= bus.in1[W-1];
            b_msb_r    <= bus.in2[W-1];
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end
        end
        SHIFT: begin
          a_r    <= {1'b0, a_r[W-1:1]};
          b_r    <= {1'b0, b_r[W-1:1]};
          diff_r <= {d_s, diff_r[W-1:1]};
          br_r   <= br_out_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST) begin
            // d_s is the final diff MSB on this edge
            bout_r      <= br_out_s;
            ovf_r       <= (a_msb_r ^ b_msb_r) & (d_s ^ a_msb_r);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          diff_r      <= '0;
          bout_r      <= 1'b0;
          ovf_r       <= 1'b0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors queue expectations,
// a negedge monitor pops and compares every presented result.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] d;
    logic        b;
    logic        o;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_en = 1'b0;
  logic rdy_rand = 1'b0;
  logic rdy_fix = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_ov = 1'b0;
  logic hs_pend = 1'b0;
  exp_t q[$];

  serial_subtractor_if #(.W(16)) bus ();

  serial_subtractor #(.W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.out_ready = rand_en ? rdy_rand : rdy_fix;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    rdy_rand = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: on each new out_valid, pop and compare; after a handshake out_valid must drop.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_ov <= 1'b0;
      hs_pend <= 1'b0;
    end else begin
      if (hs_pend) chk("pulse_drop", {31'd0, bus.out_valid}, 32'd0);
      if (bus.out_valid && !prev_ov) begin
        if (q.size() == 0) begin
          chk("stale_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("diff", {16'd0, bus.diff}, {16'd0, e.d});
          chk("bout", {31'd0, bus.bout}, {31'd0, e.b});
          chk("ovf", {31'd0, bus.ovf}, {31'd0, e.o});
          chk("latency", cyc - e.acc, 32'd16);
        end
      end
      hs_pend <= bus.out_valid & bus.out_ready;
      prev_ov <= bus.out_valid;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bi,
                      input logic [15:0] ed, input logic eb, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    bus.bin = bi;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      bus.in_valid = 1'b0;
    end else begin
      q.push_back('{ed, eb, eo, cyc + 1});
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] va [12] = '{16'h0005, 16'h0000, 16'h8000, 16'h1234, 16'h7FFF, 16'h4321,
                           16'hFFFF, 16'h0000, 16'h8000, 16'h00FF, 16'h1000, 16'hAAAA};
  logic [15:0] vb [12] = '{16'h0003, 16'h0001, 16'h0001, 16'h1234, 16'hFFFF, 16'h0000,
                           16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h000F, 16'h2000, 16'h5555};
  logic        vi [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                           1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] vd [12] = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h4321,
                           16'hFFFF, 16'h0000, 16'h0001, 16'h00EF, 16'hF000, 16'h5555};
  logic        vbo[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                           1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vo [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    int acc;
    bus.in_valid = 1'b0;
    bus.in1 = 16'h0000;
    bus.in2 = 16'h0000;
    bus.bin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_diff", {16'd0, bus.diff}, 32'd0);
    chk("rst_bout", {31'd0, bus.bout}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    // Directed vectors with out_ready held high.
    for (int i = 0; i < 7; i++) send(va[i], vb[i], vi[i], vd[i], vbo[i], vo[i]);
    drain();

    // Stall in DONE with a new operand pending.
    @(posedge clk);
    #1 rdy_fix = 1'b0;
    send(16'h1111, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("stall_wait", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in1 = 16'h0003;
    bus.in2 = 16'h0004;
    bus.bin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_diff", {16'd0, bus.diff}, 32'h1010);
      chk("stall_bout", {31'd0, bus.bout}, 32'd0);
      chk("stall_ovf", {31'd0, bus.ovf}, 32'd0);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(posedge clk);
    #1 rdy_fix = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    q.push_back('{16'hFFFF, 1'b1, 1'b0, cyc + 1});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();

    // Reset eight cycles into SHIFT discards the partial result.
    send(16'hAAAA, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b1);
    acc = cyc;
    while (cyc < acc + 7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_diff", {16'd0, bus.diff}, 32'd0);
    repeat (30) @(negedge clk);
    send(va[0], vb[0], vi[0], vd[0], vbo[0], vo[0]);
    drain();

    // Back-to-back with randomized out_ready.
    @(posedge clk);
    #1 rand_en = 1'b1;
    for (int i = 0; i < 12; i++) send(va[i], vb[i], vi[i], vd[i], vbo[i], vo[i]);
    @(posedge clk);
    #1 rand_en = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
